scan_decoder: RTL

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder_if.sv | 25 ++
 rtl/scan_decoder.sv | 73 +++++++
 2 files changed

// File: rtl/scan_decoder_if.sv
// scan_decoder_if: control inputs and decoded outputs of the scan decoder
interface scan_decoder_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_W = 2 ** SEL_W;

    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel_in;
    logic [SEL_W-1:0] scan_max;
    logic [OUT_W-1:0] Y;
    logic [SEL_W-1:0] cur_sel;
    logic             slot_tick;
    logic             wrap;

    modport master (
        output en, mode, sel_in, scan_max,
        input  Y, cur_sel, slot_tick, wrap
    );

    modport slave (
        input  en, mode, sel_in, scan_max,
        output Y, cur_sel, slot_tick, wrap
    );
endinterface

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with direct select or prescaled auto-scan.
// Define ACTIVE_LOW_OUT_EN for inverted (common-anode) Y drive.
module scan_decoder #(
    parameter int SEL_W    = 3,
    parameter int PRESCALE = 4
) (
    input logic         clk,
    input logic         reset,
    scan_decoder_if.slave bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam int PW    = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
`ifdef ACTIVE_LOW_OUT_EN
    localparam logic [OUT_W-1:0] OFF = '1;
`else
    localparam logic [OUT_W-1:0] OFF = '0;
`endif

    logic [OUT_W-1:0] y_q;
    logic [SEL_W-1:0] cur_q;
    logic [SEL_W-1:0] nxt;
    logic [PW-1:0]    pc;
    logic             tick_q;
    logic             wrap_q;
    logic             adv;

    // Polarity is folded in before the flop so Y stays a pure register output
    function automatic logic [OUT_W-1:0] drive(input logic [SEL_W-1:0] s);
        drive = (OUT_W'(1) << s) ^ OFF;
    endfunction

    always_comb begin
        adv = cur_q < bus.scan_max;
        nxt = adv ? cur_q + SEL_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q    <= OFF;
            cur_q  <= '0;
            pc     <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (!bus.en) begin
            y_q    <= OFF;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (!bus.mode) begin
            y_q    <= drive(bus.sel_in);
            cur_q  <= bus.sel_in;
            pc     <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (pc == LAST) begin
            y_q    <= drive(nxt);
            cur_q  <= nxt;
            pc     <= '0;
            tick_q <= 1'b1;
            wrap_q <= !adv;
        end else begin
            y_q    <= drive(cur_q);
            pc     <= pc + PW'(1);
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end
    end

    assign bus.Y         = y_q;
    assign bus.cur_sel   = cur_q;
    assign bus.slot_tick = tick_q;
    assign bus.wrap      = wrap_q;
endmodule
